// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential signed divider.
// The requester drives start/dvd/dvs; the divider drives busy, done and the results.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, dvd, dvs,
    input  busy, done, quot, rem, dbz, ovf
  );

  modport slave (
    input  start, dvd, dvs,
    output busy, done, quot, rem, dbz, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract signed divider: one quotient bit per clock on magnitudes,
// with a final sign-fix cycle. Results are registered and held until the next done.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus,
  output logic [1:0]   state_dbg
);

  // Handshake: a request is taken on any rising edge where start=1 and the block is
  // idle (busy=0); start while busy is dropped. done pulses for one cycle with results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] qm_q;
  logic [WIDTH-1:0] dvs_mag_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dbz_pend_q;
  logic             ovf_pend_q;

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             done_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;

  // Negating the most-negative value wraps to 2^(WIDTH-1), which is the correct
  // unsigned magnitude.
  assign dvd_mag = bus.dvd[WIDTH-1] ? -bus.dvd : bus.dvd;
  assign dvs_mag = bus.dvs[WIDTH-1] ? -bus.dvs : bus.dvs;
  assign p_sh    = {p_q[WIDTH-1:0], qm_q[WIDTH-1]};
  assign trial   = p_sh - {1'b0, dvs_mag_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q        <= '0;
      qm_q       <= '0;
      dvs_mag_q  <= '0;
      cnt_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q_q   <= bus.dvd[WIDTH-1] ^ bus.dvs[WIDTH-1];
            sign_r_q   <= bus.dvd[WIDTH-1];
            qm_q       <= dvd_mag;
            dvs_mag_q  <= dvs_mag;
            p_q        <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= (bus.dvs == '0);
            ovf_pend_q <= (bus.dvd == MIN_VAL) && (bus.dvs == '1);
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (!trial[WIDTH]) begin
            p_q  <= trial;
            qm_q <= {qm_q[WIDTH-2:0], 1'b1};
          end else begin
            p_q  <= p_sh;
            qm_q <= {qm_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          // A zero divisor leaves |dvd| in P, so the remainder path already yields dvd.
          quot_q <= dbz_pend_q ? '1 : (sign_q_q ? -qm_q : qm_q);
          rem_q  <= sign_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          dbz_q  <= dbz_pend_q;
          ovf_q  <= ovf_pend_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
  assign bus.dbz   = dbz_q;
  assign bus.ovf   = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at WIDTH=8 and WIDTH=16.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic [1:0] st8;
  logic [1:0] st16;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider_if #(.WIDTH(8))  s8 ();
  seq_divider_if #(.WIDTH(16)) s16 ();

  seq_divider #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (s8),
    .state_dbg (st8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (s16),
    .state_dbg (st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (8-bit instance)
  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    s8.start = 1'b1;
    s8.dvd   = a;
    s8.dvs   = b;
    @(negedge clk);
    s8.start = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (s8.done !== 1'b1 && lat < 40) begin
      if (s8.busy === 1'b1) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input logic ov);
    check({tag, ".done"}, 32'(s8.done), 32'd1);
    check({tag, ".quot"}, 32'(s8.quot), 32'(q));
    check({tag, ".rem"},  32'(s8.rem),  32'(r));
    check({tag, ".dbz"},  32'(s8.dbz),  32'(dz));
    check({tag, ".ovf"},  32'(s8.ovf),  32'(ov));
  endtask

  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input logic ov);
    int lat, bcyc;
    start8(a, b);
    wait_done8(lat, bcyc);
    check({tag, ".lat"},  32'(lat),  32'd9);
    check({tag, ".busy"}, 32'(bcyc), 32'd9);
    expect8(tag, q, r, dz, ov);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(s8.done), 32'd0);
    check({tag, ".hold"},  32'(s8.quot), 32'(q));
  endtask

  initial begin
    int lat, bcyc, n, ndone;
    s8.start  = 1'b0;  s8.dvd  = '0; s8.dvs  = '0;
    s16.start = 1'b0;  s16.dvd = '0; s16.dvs = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy",  32'(s8.busy), 32'd0);
    check("rst.done",  32'(s8.done), 32'd0);
    check("rst.quot",  32'(s8.quot), 32'd0);
    check("rst.rem",   32'(s8.rem),  32'd0);
    check("rst.state", 32'(st8),     32'd0);
    rst_n = 1'b1;

    run_op8("p100_7",  8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0);
    run_op8("n100_7",  8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op8("p100_n7", 8'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0);
    run_op8("div0",    8'd7,    8'h00,   8'hFF, 8'h07, 1'b1, 1'b0);
    run_op8("ndiv0",   8'hF9,   8'h00,   8'hFF, 8'hF9, 1'b1, 1'b0);
    run_op8("ovf",     8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1);
    run_op8("min_1",   8'h80,   8'h01,   8'h80, 8'h00, 1'b0, 1'b0);
    run_op8("small",   8'd3,    8'd9,    8'h00, 8'h03, 1'b0, 1'b0);

    // start while busy is ignored, then a start in the done cycle is taken
    start8(8'd60, 8'd5);
    repeat (2) @(negedge clk);
    s8.start = 1'b1; s8.dvd = 8'd9; s8.dvs = 8'd3;
    @(negedge clk);
    s8.start = 1'b0;
    wait_done8(lat, bcyc);
    check("ign.lat", 32'(lat), 32'd6);
    expect8("ign", 8'd12, 8'd0, 1'b0, 1'b0);
    s8.start = 1'b1; s8.dvd = 8'd9; s8.dvs = 8'd3;
    @(negedge clk);
    s8.start = 1'b0;
    check("b2b.busy", 32'(s8.busy), 32'd1);
    wait_done8(lat, bcyc);
    check("b2b.lat", 32'(lat), 32'd9);
    expect8("b2b", 8'd3, 8'd0, 1'b0, 1'b0);

    // reset mid-operation abandons the division
    start8(8'd127, 8'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst.busy",  32'(s8.busy),  32'd0);
    check("mrst.done",  32'(s8.done),  32'd0);
    check("mrst.quot",  32'(s8.quot),  32'd0);
    check("mrst.rem",   32'(s8.rem),   32'd0);
    check("mrst.flags", 32'({s8.dbz, s8.ovf}), 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (s8.done === 1'b1) ndone++;
    end
    check("mrst.nodone", 32'(ndone), 32'd0);
    run_op8("p127_1", 8'd127, 8'd1, 8'd127, 8'd0, 1'b0, 1'b0);

    // reset wins over a simultaneous start
    s8.start = 1'b1; s8.dvd = 8'd5; s8.dvs = 8'd1; rst_n = 1'b0;
    @(negedge clk);
    s8.start = 1'b0; rst_n = 1'b1;
    check("rst_start.busy", 32'(s8.busy), 32'd0);

    // start held high restarts every WIDTH+2 cycles
    @(negedge clk);
    s8.start = 1'b1; s8.dvd = 8'd50; s8.dvs = 8'd5;
    wait_done8(lat, bcyc);
    check("held.q", 32'(s8.quot), 32'd10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s8.done !== 1'b1 && n < 40);
    check("held.period", 32'(n), 32'd10);
    s8.start = 1'b0;
    repeat (12) @(negedge clk);

    // random operand pairs on both widths in parallel
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [7:0] a, b, eq, er;
          int qi, ri, l8;
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          if (b == 8'd0) b = 8'd1;
          qi = int'($signed(a)) / int'($signed(b));
          ri = int'($signed(a)) % int'($signed(b));
          eq = qi[7:0];
          er = ri[7:0];
          @(negedge clk);
          s8.start = 1'b1; s8.dvd = a; s8.dvs = b;
          @(negedge clk);
          s8.start = 1'b0;
          l8 = 0;
          while (s8.done !== 1'b1 && l8 < 40) begin
            @(negedge clk);
            l8++;
          end
          check("r8.lat",  32'(l8),      32'd9);
          check("r8.quot", 32'(s8.quot), 32'(eq));
          check("r8.rem",  32'(s8.rem),  32'(er));
          check("r8.ovf",  32'({s8.dbz, s8.ovf}),
                32'({1'b0, (a == 8'h80) && (b == 8'hFF)}));
        end
      end
      begin
        for (int j = 0; j < 2000; j++) begin
          logic [15:0] a, b, eq, er;
          int qi, ri, l16;
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(0, 65535));
          if (j % 4 == 1) b = 16'($urandom_range(0, 31)) ^ {16{b[15]}};
          if (j == 7) begin a = 16'h8000; b = 16'hFFFF; end
          if (b == 16'd0) b = 16'd3;
          qi = int'($signed(a)) / int'($signed(b));
          ri = int'($signed(a)) % int'($signed(b));
          eq = qi[15:0];
          er = ri[15:0];
          @(negedge clk);
          s16.start = 1'b1; s16.dvd = a; s16.dvs = b;
          @(negedge clk);
          s16.start = 1'b0;
          l16 = 0;
          while (s16.done !== 1'b1 && l16 < 60) begin
            @(negedge clk);
            l16++;
          end
          check("r16.lat",  32'(l16),      32'd17);
          check("r16.quot", 32'(s16.quot), 32'(eq));
          check("r16.rem",  32'(s16.rem),  32'(er));
          check("r16.ovf",  32'({s16.dbz, s16.ovf}),
                32'({1'b0, (a == 16'h8000) && (b == 16'hFFFF)}));
        end
      end
    join

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed divider built on a restoring shift-subtract algorithm. It is the inverse companion to the team's Booth multiplier and uses the same start/busy handshake style.
- Computes quotient and remainder of two's-complement operands, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath. Consumers latch results on the done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 2).
- CW, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock only.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- start  input  1  request; dvd and dvs are captured on the rising edge where start=1 while idle.
- dvd  input  WIDTH  signed dividend.
- dvs  input  WIDTH  signed divisor.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; quot, rem, dbz and ovf are valid from this cycle on.
- quot  output  WIDTH  signed quotient.
- rem  output  WIDTH  signed remainder.
- dbz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  overflow flag for the last result (most-negative / -1).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, quot=0, rem=0, dbz=0, ovf=0.
  - Counter and internal registers are cleared.
  - Applies mid-operation: any operation in progress is abandoned and no done is issued.
- States:
  - IDLE -> CALC on start=1.
  - CALC -> FIX when the iteration counter reaches WIDTH.
  - FIX -> IDLE unconditionally.
- Start capture (IDLE, start=1):
  - Latch sign_q = dvd[MSB]^dvs[MSB] and sign_r = dvd[MSB].
  - Latch |dvd| and |dvs| as unsigned WIDTH-bit magnitudes. The magnitude of the most-negative value is 2^(WIDTH-1), which is representable.
  - Clear the partial remainder P (WIDTH+1 bits) and the counter.
  - Set busy=1 and clear done.
- CALC, one iteration per cycle:
  - Shift {P, Qm} left by 1.
  - T = P - {0,|dvs|}.
  - If T is non-negative: P=T and Qm[0]=1. Otherwise P is unchanged and Qm[0]=0.
  - Counter increments each iteration.
- FIX, one cycle:
  - quot = sign_q ? -Qm : Qm.
  - rem = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - Set done=1 and busy=0 for that cycle.
- Rounding: truncation toward zero. The remainder takes the sign of the dividend, matching Verilog / and % on signed values.
- Divide by zero (dvs=0):
  - Flag captured at start.
  - Same latency as a normal division.
  - quot = all ones, rem = dvd, dbz=1, ovf=0.
- Overflow (dvd = -2^(WIDTH-1), dvs = -1):
  - quot = -2^(WIDTH-1) (wrapped), rem = 0, ovf=1.
- Latency:
  - busy is high for exactly WIDTH+1 cycles after the start edge.
  - done is asserted in the cycle after the (WIDTH+1)th edge following the start edge.
- Result holding:
  - quot, rem, dbz and ovf hold until the next done or reset.
  - done is low in all other cycles.
- start handling:
  - start while busy=1 is ignored; operands are not re-captured and the operation in progress is unaffected.
  - start asserted in the done cycle is accepted, because the state is already IDLE; this gives back-to-back operation.
  - start held high continuously restarts the block every WIDTH+2 cycles.
- dvd and dvs changing after capture have no effect.
- Simultaneous rst_n=0 and start=1: reset wins.

Test Plan:
- Reset, then start with dvd=100, dvs=7 -> busy high for 9 cycles; done pulse 9 cycles after the start edge; quot=14 (0x0E), rem=2, dbz=0, ovf=0.
- dvd=-100 (0x9C), dvs=7 -> quot=0xF2 (-14), rem=0xFE (-2). Also dvd=100, dvs=-7 -> quot=0xF2, rem=0x02.
- dvd=7, dvs=0 -> quot=0xFF, rem=0x07, dbz=1, same 9-cycle latency. Then dvd=-128 (0x80), dvs=-1 (0xFF) -> quot=0x80, rem=0x00, ovf=1, dbz=0.
- Start 60/5. Three cycles later pulse start with 9/3 -> second request ignored; result quot=12, rem=0 with a single done. Then re-assert start in the done cycle with 9/3 -> accepted; quot=3, rem=0 after 9 more cycles.
- Start 127/1. Drop rst_n for one cycle at iteration 4 -> busy=0 and all outputs 0 the next cycle; no done follows. New start 127/1 -> quot=127, rem=0.
- Randomized: 2000 random signed operand pairs, with WIDTH=8 and WIDTH=16 -> quot and rem equal the Verilog signed / and % results (excluding dvs=0); flags correct; done latency always WIDTH+1.
